// File: rtl/spw_tx_pkg.sv
// Shared constants for the SpaceWire transmit path: character codes, credit limits and scheduler states.
package spw_tx_pkg;

  typedef enum logic [2:0] {
    CHAR_NULL = 3'd0,
    CHAR_FCT  = 3'd1,
    CHAR_DATA = 3'd2,
    CHAR_EOP  = 3'd3,
    CHAR_EEP  = 3'd4,
    CHAR_TIME = 3'd5
  } char_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARB  = 2'd1,
    ST_HOLD = 2'd2
  } tx_state_t;

  localparam logic [5:0] MAX_CREDIT = 6'd56;
  localparam logic [5:0] FCT_CREDIT = 6'd8;

  // Bit 8 marks an end-of-packet marker; a zero payload is EOP, anything else EEP.
  function automatic char_t nchar_type(input logic [8:0] head);
    if (!head[8])
      return CHAR_DATA;
    else if (head[7:0] == 8'd0)
      return CHAR_EOP;
    else
      return CHAR_EEP;
  endfunction

  function automatic logic is_nchar(input char_t t);
    return (t == CHAR_DATA) || (t == CHAR_EOP) || (t == CHAR_EEP);
  endfunction

endpackage

// File: rtl/tx_credit_counter.sv
// Transmit credit counter: +8 per received FCT, -1 per sent N-Char, saturating at 56 with an error pulse.
module tx_credit_counter
  import spw_tx_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       inc,
  input  logic       dec,
  output logic [5:0] credit,
  output logic       credit_error
);

  logic [6:0] sum;
  logic       over;
  logic [5:0] credit_next;

  // Overflow is judged on the pre-decrement value, so a rejected +8 still lets the -1 through.
  always_comb begin
    sum          = {1'b0, credit} + {1'b0, FCT_CREDIT};
    over         = inc && !clear && (sum > {1'b0, MAX_CREDIT});
    credit_error = over;
    credit_next  = credit;
    if (inc && !over)
      credit_next = sum[5:0];
    if (dec && (credit_next != '0))
      credit_next = credit_next - 6'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      credit <= '0;
    else if (clear)
      credit <= '0;
    else
      credit <= credit_next;
  end

endmodule

// File: rtl/tx_char_scheduler.sv
// SpaceWire transmit character scheduler: TIME > FCT > N-Char > NULL arbitration with registered pick.
// Optional time-code support is enabled by defining TX_TIMECODE_EN.
module tx_char_scheduler
  import spw_tx_pkg::*;
(
  input  logic       pclk_tx,
  input  logic       reset_tx,
  input  logic       send_null_tx,
  input  logic       send_fct_tx,
  input  logic       send_nchar_tx,
  input  logic [2:0] fct_flag_p,
  output logic       fct_sent,
  input  logic       fct_received,
  output logic       credit_error,
  input  logic       tick_in,
  input  logic [7:0] time_in,
  input  logic       fifo_empty,
  input  logic [8:0] fifo_data,
  output logic       fifo_rd,
  output logic       char_valid,
  input  logic       char_ready,
  output logic [2:0] char_type,
  output logic [7:0] char_data
);

  tx_state_t  state, state_next;
  char_t      pick_type, hold_type;
  logic [7:0] pick_data, hold_data;
  logic       any_send;
  logic       accept;
  logic [5:0] credit;
  logic       tick_pending;
  logic [7:0] tick_value;

  assign any_send = send_null_tx || send_fct_tx || send_nchar_tx;

  tx_credit_counter u_credit (
    .clk          (pclk_tx),
    .rst          (reset_tx),
    .clear        (!any_send),
    .inc          (fct_received),
    .dec          (fifo_rd),
    .credit       (credit),
    .credit_error (credit_error)
  );

`ifdef TX_TIMECODE_EN
  // A tick coinciding with acceptance of the previous time-code re-arms the latch.
  always_ff @(posedge pclk_tx or posedge reset_tx) begin
    if (reset_tx) begin
      tick_pending <= 1'b0;
      tick_value   <= '0;
    end else if (!any_send) begin
      tick_pending <= 1'b0;
    end else if (tick_in) begin
      tick_pending <= 1'b1;
      tick_value   <= time_in;
    end else if (accept && (hold_type == CHAR_TIME)) begin
      tick_pending <= 1'b0;
    end
  end
`else
  logic tick_unused;
  assign tick_unused  = tick_in ^ (^time_in);
  assign tick_pending = 1'b0;
  assign tick_value   = '0;
`endif

  always_ff @(posedge pclk_tx or posedge reset_tx) begin
    if (reset_tx)
      state <= ST_IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (!any_send) begin
      state_next = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: state_next = ST_ARB;
        ST_ARB:  state_next = ST_HOLD;
        ST_HOLD: if (accept) state_next = ST_ARB;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    pick_type = CHAR_NULL;
    pick_data = '0;
    if (send_nchar_tx && tick_pending) begin
      pick_type = CHAR_TIME;
      pick_data = tick_value;
    end else if ((send_fct_tx || send_nchar_tx) && (fct_flag_p != '0)) begin
      pick_type = CHAR_FCT;
    end else if (send_nchar_tx && !fifo_empty && (credit != '0)) begin
      pick_type = nchar_type(fifo_data);
      pick_data = fifo_data[8] ? '0 : fifo_data[7:0];
    end
  end

  always_ff @(posedge pclk_tx or posedge reset_tx) begin
    if (reset_tx) begin
      hold_type <= CHAR_NULL;
      hold_data <= '0;
    end else if (!any_send) begin
      hold_type <= CHAR_NULL;
      hold_data <= '0;
    end else if (state == ST_ARB) begin
      hold_type <= pick_type;
      hold_data <= pick_data;
    end
  end

  always_comb begin
    char_valid = (state == ST_HOLD);
    accept     = char_valid && char_ready;
    fct_sent   = accept && (hold_type == CHAR_FCT);
    fifo_rd    = accept && is_nchar(hold_type);
    char_type  = hold_type;
    char_data  = hold_data;
  end

endmodule

// File: tb/tb_tx_char_scheduler.sv
// Directed scoreboard bench for tx_char_scheduler; non-NULL characters are checked in order against a queue.
module tb_tx_char_scheduler;
  import spw_tx_pkg::*;

  logic       pclk_tx = 1'b0;
  logic       reset_tx, send_null_tx, send_fct_tx, send_nchar_tx;
  logic [2:0] fct_flag_p;
  logic       fct_sent, fct_received, credit_error, tick_in;
  logic [7:0] time_in;
  logic       fifo_empty, fifo_rd, char_valid, char_ready;
  logic [8:0] fifo_data;
  logic [2:0] char_type;
  logic [7:0] char_data;

  typedef struct packed {
    logic [2:0] t;
    logic [7:0] d;
  } exp_t;

  exp_t        exp_q[$];
  logic [8:0]  fifo_q[$];
  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned null_cnt, fct_cnt, err_cnt, valid_cnt;

  always #5 pclk_tx = ~pclk_tx;

  tx_char_scheduler dut (
    .pclk_tx       (pclk_tx),
    .reset_tx      (reset_tx),
    .send_null_tx  (send_null_tx),
    .send_fct_tx   (send_fct_tx),
    .send_nchar_tx (send_nchar_tx),
    .fct_flag_p    (fct_flag_p),
    .fct_sent      (fct_sent),
    .fct_received  (fct_received),
    .credit_error  (credit_error),
    .tick_in       (tick_in),
    .time_in       (time_in),
    .fifo_empty    (fifo_empty),
    .fifo_data     (fifo_data),
    .fifo_rd       (fifo_rd),
    .char_valid    (char_valid),
    .char_ready    (char_ready),
    .char_type     (char_type),
    .char_data     (char_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic sync_fifo();
    fifo_empty = (fifo_q.size() == 0);
    fifo_data  = fifo_empty ? 9'h000 : fifo_q[0];
  endtask

  task automatic push_byte(input logic [8:0] b, input logic expect_it);
    exp_t e;
    fifo_q.push_back(b);
    if (expect_it) begin
      e.t = nchar_type(b);
      e.d = b[8] ? 8'h00 : b[7:0];
      exp_q.push_back(e);
    end
    sync_fifo();
  endtask

  task automatic expect_char(input char_t t, input logic [7:0] d);
    exp_t e;
    e.t = t;
    e.d = d;
    exp_q.push_back(e);
  endtask

  // One clock: sample at the falling edge, then update the FIFO / FCT environment after the rising edge.
  task automatic step();
    exp_t e;
    logic pop, dfct;
    @(negedge pclk_tx);
    pop  = 1'b0;
    dfct = 1'b0;
    if (credit_error) err_cnt++;
    if (char_valid)   valid_cnt++;
    if (fct_sent)     fct_cnt++;
    if (char_valid && char_ready) begin
      if (char_type == CHAR_NULL) begin
        null_cnt++;
        chk("null_fct_sent", 32'(fct_sent), 32'd0);
        chk("null_fifo_rd", 32'(fifo_rd), 32'd0);
      end else if (exp_q.size() == 0) begin
        chk("unexpected_char", 32'(char_type), 32'(CHAR_NULL));
      end else begin
        e = exp_q.pop_front();
        chk("char_type", 32'(char_type), 32'(e.t));
        chk("char_data", 32'(char_data), 32'(e.d));
        chk("fct_sent", 32'(fct_sent), 32'(e.t == CHAR_FCT));
        chk("fifo_rd", 32'(fifo_rd), 32'(is_nchar(char_t'(e.t))));
      end
      pop  = fifo_rd;
      dfct = fct_sent;
    end else begin
      chk("idle_fct_sent", 32'(fct_sent), 32'd0);
      chk("idle_fifo_rd", 32'(fifo_rd), 32'd0);
    end
    @(posedge pclk_tx);
    #1;
    if (pop && fifo_q.size() > 0) fifo_q.delete(0);
    if (dfct && fct_flag_p != 3'd0) fct_flag_p = fct_flag_p - 3'd1;
    sync_fifo();
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 60; i++) begin
      if (exp_q.size() == 0) break;
      step();
    end
    chk(tag, 32'(exp_q.size()), 32'd0);
  endtask

  // Run until the scheduler sits in arbitration, then stall the serializer.
  task automatic freeze();
    for (int i = 0; i < 20; i++) begin
      step();
      if (!char_valid) break;
    end
    chk("freeze_arb", 32'(char_valid), 32'd0);
    char_ready = 1'b0;
  endtask

  task automatic fct_pulse();
    fct_received = 1'b1;
    step();
    fct_received = 1'b0;
  endtask

  initial begin
    reset_tx = 1'b1;
    send_null_tx = 1'b0; send_fct_tx = 1'b0; send_nchar_tx = 1'b0;
    fct_flag_p = 3'd0; fct_received = 1'b0; tick_in = 1'b0; time_in = 8'h00;
    char_ready = 1'b0;
    null_cnt = 0; fct_cnt = 0; err_cnt = 0; valid_cnt = 0;
    sync_fifo();
    repeat (3) @(posedge pclk_tx);
    @(negedge pclk_tx);
    chk("rst_valid", 32'(char_valid), 32'd0);
    chk("rst_type", 32'(char_type), 32'(CHAR_NULL));
    chk("rst_data", 32'(char_data), 32'd0);
    chk("rst_fifo_rd", 32'(fifo_rd), 32'd0);
    chk("rst_fct_sent", 32'(fct_sent), 32'd0);
    chk("rst_credit_error", 32'(credit_error), 32'd0);
    chk("rst_credit", 32'(dut.u_credit.credit), 32'd0);
    @(posedge pclk_tx);
    #1;
    reset_tx = 1'b0;

    // NULL-only stream
    send_null_tx = 1'b1;
    char_ready   = 1'b1;
    repeat (20) step();
    chk("null_valid_cnt", valid_cnt, 32'd9);
    chk("null_accept_cnt", null_cnt, 32'd9);
    chk("null_no_fct", fct_cnt, 32'd0);

    // Connecting: FCTs only
    send_fct_tx = 1'b1; send_null_tx = 1'b0;
    fct_flag_p = 3'd7;
    for (int i = 0; i < 7; i++) expect_char(CHAR_FCT, 8'h00);
    null_cnt = 0; fct_cnt = 0;
    repeat (20) step();
    chk("fct_cnt", fct_cnt, 32'd7);
    chk("fct_flag_zero", 32'(fct_flag_p), 32'd0);
    chk("fct_queue", 32'(exp_q.size()), 32'd0);
    chk("fct_then_null", null_cnt, 32'd3);

    // Run with no credit, then one FCT of credit
    send_nchar_tx = 1'b1; send_fct_tx = 1'b0;
    push_byte(9'h041, 1'b0);
    push_byte(9'h042, 1'b0);
    push_byte(9'h100, 1'b0);
    repeat (10) step();
    chk("nocredit_fifo", 32'(fifo_q.size()), 32'd3);
    chk("nocredit_credit", 32'(dut.u_credit.credit), 32'd0);
    expect_char(CHAR_DATA, 8'h41);
    expect_char(CHAR_DATA, 8'h42);
    expect_char(CHAR_EOP, 8'h00);
    fct_pulse();
    drain("nchar_drain");
    repeat (4) step();
    chk("nchar_credit", 32'(dut.u_credit.credit), 32'd5);
    chk("nchar_fifo_empty", 32'(fifo_q.size()), 32'd0);
    chk("nchar_no_err", err_cnt, 32'd0);

    // Leaving the link states clears credit
    send_nchar_tx = 1'b0;
    step(); step();
    chk("idle_credit", 32'(dut.u_credit.credit), 32'd0);
    chk("idle_valid", 32'(char_valid), 32'd0);
    send_nchar_tx = 1'b1;

    // Saturation at 56
    err_cnt = 0;
    for (int i = 0; i < 7; i++) begin
      fct_pulse();
      step();
    end
    chk("credit_56", 32'(dut.u_credit.credit), 32'd56);
    chk("credit_56_no_err", err_cnt, 32'd0);
    fct_pulse();
    step();
    chk("overflow_err", err_cnt, 32'd1);
    chk("overflow_credit", 32'(dut.u_credit.credit), 32'd56);

    // 50 with simultaneous FCT and DATA accept: +8 rejected, -1 applied
    for (int i = 0; i < 6; i++) push_byte(9'(8'h10 + i), 1'b1);
    drain("drain_to_50");
    freeze();
    push_byte(9'h016, 1'b1);
    step();
    chk("hold50_valid", 32'(char_valid), 32'd1);
    chk("hold50_credit", 32'(dut.u_credit.credit), 32'd50);
    fct_received = 1'b1; char_ready = 1'b1;
    step();
    fct_received = 1'b0;
    chk("dual50_err", err_cnt, 32'd2);
    chk("dual50_credit", 32'(dut.u_credit.credit), 32'd49);

    // 48 with the same double event: net +7
    push_byte(9'h017, 1'b1);
    drain("drain_to_48");
    freeze();
    push_byte(9'h018, 1'b1);
    step();
    chk("hold48_credit", 32'(dut.u_credit.credit), 32'd48);
    fct_received = 1'b1; char_ready = 1'b1;
    step();
    fct_received = 1'b0;
    chk("dual48_err", err_cnt, 32'd2);
    chk("dual48_credit", 32'(dut.u_credit.credit), 32'd55);

    // Priority with a time-code; a second tick overwrites the first
    freeze();
    step();
    fct_flag_p = 3'd1;
    tick_in = 1'b1; time_in = 8'h11;
`ifdef TX_TIMECODE_EN
    expect_char(CHAR_TIME, 8'h23);
`endif
    expect_char(CHAR_FCT, 8'h00);
    push_byte(9'h055, 1'b1);
    step();
    time_in = 8'h23;
    step();
    tick_in = 1'b0; time_in = 8'h00;
    char_ready = 1'b1;
    drain("prio_drain");
    repeat (4) step();
    chk("prio_fct_flag", 32'(fct_flag_p), 32'd0);

    // Drop the link while a DATA character is stalled
    freeze();
    push_byte(9'h077, 1'b0);
    step();
    chk("drop_hold_valid", 32'(char_valid), 32'd1);
    chk("drop_hold_type", 32'(char_type), 32'(CHAR_DATA));
    chk("drop_hold_data", 32'(char_data), 32'h77);
    send_nchar_tx = 1'b0;
    step();
    step();
    chk("drop_valid", 32'(char_valid), 32'd0);
    chk("drop_credit", 32'(dut.u_credit.credit), 32'd0);
    chk("drop_fifo_kept", 32'(fifo_q.size()), 32'd1);
    chk("final_queue", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
